// File: rtl/axi_lite_arb_pkg.sv
// Shared types and constants for the two-requester AXI4-Lite master arbiter.
package axi_lite_arb_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned RESP_W = 2;

  localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] RESP_EXOKAY = 2'b01;
  localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;
  localparam logic [RESP_W-1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_DONE
  } arb_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } wr_payload_t;

  // SLVERR and DECERR both report an error to the requester.
  function automatic logic resp_is_err(input logic [RESP_W-1:0] resp);
    return !(resp inside {RESP_OKAY, RESP_EXOKAY});
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: on a tie the requester not granted last wins.
module rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  input  logic       enable,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      if (valid == 2'b11) grant = last_grant ? 2'b01 : 2'b10;
      else                grant = valid;
    end
  end

endmodule

// File: rtl/axi_lite_master_arbiter.sv
// Shares one AXI4-Lite master port between two single-beat requesters,
// one transaction outstanding at a time, round-robin granted.
module axi_lite_master_arbiter
  import axi_lite_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  AXI_CLK,
  input  logic                  RESET,
  input  logic                  req0_valid,
  input  logic                  req0_write,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_W-1:0]     req0_wdata,
  input  logic [STRB_W-1:0]     req0_wstrb,
  output logic                  req0_accept,
  output logic                  req0_done,
  output logic [DATA_W-1:0]     req0_rdata,
  output logic                  req0_err,
  input  logic                  req1_valid,
  input  logic                  req1_write,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_W-1:0]     req1_wdata,
  input  logic [STRB_W-1:0]     req1_wstrb,
  output logic                  req1_accept,
  output logic                  req1_done,
  output logic [DATA_W-1:0]     req1_rdata,
  output logic                  req1_err,
  output logic [ADDR_WIDTH-1:0] AXI_araddr,
  output logic [2:0]            AXI_arprot,
  output logic                  AXI_arvalid,
  input  logic                  AXI_arready,
  input  logic [DATA_W-1:0]     AXI_rdata,
  input  logic [RESP_W-1:0]     AXI_rresp,
  input  logic                  AXI_rvalid,
  output logic                  AXI_rready,
  output logic [ADDR_WIDTH-1:0] AXI_awaddr,
  output logic [2:0]            AXI_awprot,
  output logic                  AXI_awvalid,
  input  logic                  AXI_awready,
  output logic [DATA_W-1:0]     AXI_wdata,
  output logic [STRB_W-1:0]     AXI_wstrb,
  output logic                  AXI_wvalid,
  input  logic                  AXI_wready,
  input  logic [RESP_W-1:0]     AXI_bresp,
  input  logic                  AXI_bvalid,
  output logic                  AXI_bready
);

  arb_state_e            state, state_nx;
  logic                  owner, last_grant, aw_ok, w_ok;
  logic [1:0]            grant, done_q, err_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  wr_payload_t           pl_q;
  logic [DATA_W-1:0]     rdata0_q, rdata1_q;

  rr_arbiter2 u_arb (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant),
    .enable     (state == ST_IDLE),
    .grant      (grant)
  );

  assign req0_accept = grant[0];
  assign req1_accept = grant[1];
  assign req0_done   = done_q[0];
  assign req1_done   = done_q[1];
  assign req0_err    = err_q[0];
  assign req1_err    = err_q[1];
  assign req0_rdata  = rdata0_q;
  assign req1_rdata  = rdata1_q;

  // Bus address/data come only from the latched request.
  assign AXI_araddr = addr_q;
  assign AXI_awaddr = addr_q;
  assign AXI_wdata  = pl_q.wdata;
  assign AXI_wstrb  = pl_q.wstrb;
  assign AXI_arprot = 3'b000;
  assign AXI_awprot = 3'b000;

  always_ff @(posedge AXI_CLK or posedge RESET) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    AXI_arvalid = 1'b0;
    AXI_rready  = 1'b0;
    AXI_awvalid = 1'b0;
    AXI_wvalid  = 1'b0;
    AXI_bready  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (grant[0])      state_nx = req0_write ? ST_WR_REQ : ST_RD_ADDR;
        else if (grant[1]) state_nx = req1_write ? ST_WR_REQ : ST_RD_ADDR;
      end
      ST_RD_ADDR: begin
        AXI_arvalid = 1'b1;
        if (AXI_arready) state_nx = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        AXI_rready = 1'b1;
        if (AXI_rvalid) state_nx = ST_DONE;
      end
      ST_WR_REQ: begin
        AXI_awvalid = !aw_ok;
        AXI_wvalid  = !w_ok;
        if ((aw_ok || AXI_awready) && (w_ok || AXI_wready)) state_nx = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        AXI_bready = 1'b1;
        if (AXI_bvalid) state_nx = ST_DONE;
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Request latch, per-channel write handshake flags and per-owner results.
  always_ff @(posedge AXI_CLK or posedge RESET) begin
    if (RESET) begin
      owner      <= 1'b0;
      last_grant <= 1'b1;
      addr_q     <= '0;
      pl_q       <= '0;
      aw_ok      <= 1'b0;
      w_ok       <= 1'b0;
      done_q     <= 2'b00;
      err_q      <= 2'b00;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      done_q <= 2'b00;
      case (state)
        ST_IDLE: begin
          if (|grant) begin
            owner      <= grant[1];
            addr_q     <= grant[1] ? req1_addr : req0_addr;
            pl_q.wdata <= grant[1] ? req1_wdata : req0_wdata;
            pl_q.wstrb <= grant[1] ? req1_wstrb : req0_wstrb;
            aw_ok      <= 1'b0;
            w_ok       <= 1'b0;
          end
        end
        ST_RD_DATA: begin
          if (AXI_rvalid) begin
            if (owner) rdata1_q <= AXI_rdata;
            else       rdata0_q <= AXI_rdata;
            err_q[owner]  <= resp_is_err(AXI_rresp);
            done_q[owner] <= 1'b1;
          end
        end
        ST_WR_REQ: begin
          if (AXI_awvalid && AXI_awready) aw_ok <= 1'b1;
          if (AXI_wvalid && AXI_wready)   w_ok  <= 1'b1;
        end
        ST_WR_RESP: begin
          if (AXI_bvalid) begin
            err_q[owner]  <= resp_is_err(AXI_bresp);
            done_q[owner] <= 1'b1;
          end
        end
        ST_DONE: last_grant <= owner;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_master_arbiter.sv
// Bench for axi_lite_master_arbiter: transaction-level model, scripted slave,
// per-cycle comparison plus hand-computed checks.
module tb_axi_lite_master_arbiter;

  logic        AXI_CLK = 1'b0;
  logic        RESET;
  logic        req_valid [2];
  logic        req_write [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_wstrb [2];
  logic        req0_accept, req1_accept, req0_done, req1_done, req0_err, req1_err;
  logic [31:0] req0_rdata, req1_rdata;
  logic [31:0] AXI_araddr, AXI_awaddr, AXI_rdata, AXI_wdata;
  logic [2:0]  AXI_arprot, AXI_awprot;
  logic        AXI_arvalid, AXI_arready, AXI_rvalid, AXI_rready;
  logic        AXI_awvalid, AXI_awready, AXI_wvalid, AXI_wready, AXI_bvalid, AXI_bready;
  logic [1:0]  AXI_rresp, AXI_bresp;
  logic [3:0]  AXI_wstrb;

  always #5 AXI_CLK = ~AXI_CLK;

  axi_lite_master_arbiter #(.ADDR_WIDTH(32)) dut (
    .AXI_CLK(AXI_CLK), .RESET(RESET),
    .req0_valid(req_valid[0]), .req0_write(req_write[0]), .req0_addr(req_addr[0]),
    .req0_wdata(req_wdata[0]), .req0_wstrb(req_wstrb[0]), .req0_accept(req0_accept),
    .req0_done(req0_done), .req0_rdata(req0_rdata), .req0_err(req0_err),
    .req1_valid(req_valid[1]), .req1_write(req_write[1]), .req1_addr(req_addr[1]),
    .req1_wdata(req_wdata[1]), .req1_wstrb(req_wstrb[1]), .req1_accept(req1_accept),
    .req1_done(req1_done), .req1_rdata(req1_rdata), .req1_err(req1_err),
    .AXI_araddr(AXI_araddr), .AXI_arprot(AXI_arprot), .AXI_arvalid(AXI_arvalid),
    .AXI_arready(AXI_arready), .AXI_rdata(AXI_rdata), .AXI_rresp(AXI_rresp),
    .AXI_rvalid(AXI_rvalid), .AXI_rready(AXI_rready),
    .AXI_awaddr(AXI_awaddr), .AXI_awprot(AXI_awprot), .AXI_awvalid(AXI_awvalid),
    .AXI_awready(AXI_awready), .AXI_wdata(AXI_wdata), .AXI_wstrb(AXI_wstrb),
    .AXI_wvalid(AXI_wvalid), .AXI_wready(AXI_wready), .AXI_bresp(AXI_bresp),
    .AXI_bvalid(AXI_bvalid), .AXI_bready(AXI_bready)
  );

  logic [1:0]  dut_acc, dut_done, dut_err;
  logic [31:0] dut_rdata [2];
  assign dut_acc      = {req1_accept, req0_accept};
  assign dut_done     = {req1_done, req0_done};
  assign dut_err      = {req1_err, req0_err};
  assign dut_rdata[0] = req0_rdata;
  assign dut_rdata[1] = req1_rdata;

  int n_cmp = 0, n_fail = 0, cyc = 0;
  logic cmp_en = 1'b0;
  int acc_cyc [2];
  int done_cyc [2];
  int grant_log [$];

  always @(posedge AXI_CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  logic        m_busy, m_owner, m_last, m_done, m_ar, m_r, m_aw, m_w, m_b;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_wstrb;
  logic [31:0] m_rdata [2];
  logic        m_err [2];
  logic [1:0]  m_acc;

  function automatic logic [1:0] exp_acc(input logic v0, input logic v1,
                                         input logic last, input logic busy);
    if (busy) return 2'b00;
    if (v0 && v1) return last ? 2'b01 : 2'b10;
    return {v1, v0};
  endfunction

  assign m_acc = exp_acc(req_valid[0], req_valid[1], m_last, m_busy);

  always @(posedge AXI_CLK or posedge RESET) begin
    if (RESET) begin
      m_busy <= 1'b0; m_owner <= 1'b0; m_last <= 1'b1; m_done <= 1'b0;
      m_ar <= 1'b0; m_r <= 1'b0; m_aw <= 1'b0; m_w <= 1'b0; m_b <= 1'b0;
      m_addr <= '0; m_wdata <= '0; m_wstrb <= '0;
      m_rdata[0] <= '0; m_rdata[1] <= '0; m_err[0] <= 1'b0; m_err[1] <= 1'b0;
    end else if (m_done) begin
      m_done <= 1'b0; m_busy <= 1'b0; m_last <= m_owner;
    end else if (!m_busy) begin
      if (m_acc != 2'b00) begin
        m_busy  <= 1'b1;
        m_owner <= m_acc[1];
        m_addr  <= req_addr[m_acc[1]];
        m_wdata <= req_wdata[m_acc[1]];
        m_wstrb <= req_wstrb[m_acc[1]];
        m_ar    <= !req_write[m_acc[1]];
        m_aw    <= req_write[m_acc[1]];
        m_w     <= req_write[m_acc[1]];
      end
    end else begin
      if (m_ar && AXI_arready) begin m_ar <= 1'b0; m_r <= 1'b1; end
      if (m_r && AXI_rvalid) begin
        m_r <= 1'b0; m_done <= 1'b1;
        m_rdata[m_owner] <= AXI_rdata; m_err[m_owner] <= AXI_rresp[1];
      end
      if (m_aw && AXI_awready) m_aw <= 1'b0;
      if (m_w && AXI_wready) m_w <= 1'b0;
      if ((m_aw || m_w) && (!m_aw || AXI_awready) && (!m_w || AXI_wready)) m_b <= 1'b1;
      if (m_b && AXI_bvalid) begin
        m_b <= 1'b0; m_done <= 1'b1; m_err[m_owner] <= AXI_bresp[1];
      end
    end
  end

  // Per-cycle comparison against the model.
  initial forever begin
    @(negedge AXI_CLK);
    if (!RESET && cmp_en) begin
      chk("accept", dut_acc, m_acc);
      chk("done", dut_done, m_done ? (m_owner ? 2'b10 : 2'b01) : 2'b00);
      for (int n = 0; n < 2; n++) begin
        chk($sformatf("rdata%0d", n), dut_rdata[n], m_rdata[n]);
        if (m_done && (m_owner == n[0])) chk($sformatf("err%0d", n), dut_err[n], m_err[n]);
      end
      chk("arvalid", AXI_arvalid, m_ar);
      chk("rready", AXI_rready, m_r);
      chk("awvalid", AXI_awvalid, m_aw);
      chk("wvalid", AXI_wvalid, m_w);
      chk("bready", AXI_bready, m_b);
      if (m_ar) chk("araddr", AXI_araddr, m_addr);
      if (m_aw) chk("awaddr", AXI_awaddr, m_addr);
      if (m_w) begin
        chk("wdata", AXI_wdata, m_wdata);
        chk("wstrb", AXI_wstrb, m_wstrb);
      end
      chk("prot", {AXI_arprot, AXI_awprot}, 6'd0);
    end
  end

  // ---------------- scripted slave ----------------
  int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
  logic [31:0] s_rdata = '0;
  logic [1:0]  s_rresp = 2'b00, s_bresp = 2'b00;

  initial begin
    int ar_c, r_c, aw_c, w_c, b_c;
    ar_c = 0; r_c = 0; aw_c = 0; w_c = 0; b_c = 0;
    AXI_arready = 0; AXI_rvalid = 0; AXI_awready = 0; AXI_wready = 0; AXI_bvalid = 0;
    AXI_rdata = '0; AXI_rresp = '0; AXI_bresp = '0;
    forever begin
      @(posedge AXI_CLK); #1;
      if (AXI_arvalid) begin AXI_arready = (ar_c >= ar_dly); ar_c++; end
      else begin AXI_arready = 0; ar_c = 0; end
      if (AXI_awvalid) begin AXI_awready = (aw_c >= aw_dly); aw_c++; end
      else begin AXI_awready = 0; aw_c = 0; end
      if (AXI_wvalid) begin AXI_wready = (w_c >= w_dly); w_c++; end
      else begin AXI_wready = 0; w_c = 0; end
      if (AXI_rready) begin
        AXI_rvalid = (r_c >= r_dly); AXI_rdata = s_rdata; AXI_rresp = s_rresp; r_c++;
      end else begin AXI_rvalid = 0; r_c = 0; end
      if (AXI_bready) begin AXI_bvalid = (b_c >= b_dly); AXI_bresp = s_bresp; b_c++; end
      else begin AXI_bvalid = 0; b_c = 0; end
    end
  end

  // ---------------- requester drivers ----------------
  task automatic issue(input int n, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    bit got = 0;
    @(posedge AXI_CLK); #1;
    req_valid[n] = 1; req_write[n] = wr; req_addr[n] = a; req_wdata[n] = d; req_wstrb[n] = s;
    for (int k = 0; k < 300; k++) begin
      @(negedge AXI_CLK);
      if (dut_acc[n]) begin got = 1; acc_cyc[n] = cyc; grant_log.push_back(n); break; end
    end
    if (!got) chk($sformatf("accept_timeout%0d", n), 0, 1);
    @(posedge AXI_CLK); #1;
    // Scramble the inputs: the latched request must be unaffected.
    req_valid[n] = 0; req_write[n] = !wr; req_addr[n] = 32'hFFFF_FFFF;
    req_wdata[n] = 32'hFFFF_FFFF; req_wstrb[n] = 4'hF;
  endtask

  task automatic wait_done(input int n);
    bit got = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge AXI_CLK);
      if (dut_done[n]) begin got = 1; done_cyc[n] = cyc; break; end
    end
    if (!got) chk($sformatf("done_timeout%0d", n), 0, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int n = 0; n < 2; n++) begin
      req_valid[n] = 0; req_write[n] = 0; req_addr[n] = '0; req_wdata[n] = '0; req_wstrb[n] = '0;
    end
    RESET = 1;
    repeat (3) @(posedge AXI_CLK);
    @(negedge AXI_CLK);
    chk("rst_arvalid", AXI_arvalid, 0);
    chk("rst_awvalid_wvalid", {AXI_awvalid, AXI_wvalid}, 0);
    chk("rst_ready", {AXI_rready, AXI_bready}, 0);
    chk("rst_addr", {AXI_araddr, AXI_awaddr}, 0);
    chk("rst_done_err", {dut_done, dut_err}, 0);
    chk("rst_rdata", {req0_rdata, req1_rdata}, 0);
    RESET = 0;
    cmp_en = 1;

    // Tie at reset release: grants alternate starting with req0.
    s_rdata = 32'h0BAD_F00D;
    for (int r = 0; r < 4; r++) begin
      fork
        issue(0, r[0], 32'h100 + r, 32'h11 * r, 4'h3);
        issue(1, !r[0], 32'h200 + r, 32'h22 * r, 4'hC);
      join
      wait_done(grant_log[grant_log.size()-1]);
    end
    chk("tie_order0", grant_log[0], 0);
    chk("tie_order1", grant_log[1], 1);
    chk("tie_order2", grant_log[2], 0);
    chk("tie_order3", grant_log[3], 1);
    @(negedge AXI_CLK);

    // Single zero-wait read from req0.
    s_rdata = 32'hDEAD_BEEF;
    issue(0, 0, 32'h0000_1234, 32'h0, 4'h0);
    @(negedge AXI_CLK);
    chk("rd_c1_arvalid", AXI_arvalid, 1);
    chk("rd_c1_araddr", AXI_araddr, 32'h0000_1234);
    @(negedge AXI_CLK);
    chk("rd_c2_rready", AXI_rready, 1);
    wait_done(0);
    chk("rd_latency", done_cyc[0] - acc_cyc[0], 3);
    chk("rd_rdata", req0_rdata, 32'hDEAD_BEEF);
    chk("rd_err", req0_err, 0);
    chk("rd_no_done1", req1_done, 0);

    // Write with awready at cycle 3, wready at cycle 1.
    aw_dly = 2;
    issue(0, 1, 32'h10, 32'hA5, 4'b0001);
    @(negedge AXI_CLK);
    chk("wr_c1_valids", {AXI_awvalid, AXI_wvalid}, 2'b11);
    @(negedge AXI_CLK);
    chk("wr_c2_valids", {AXI_awvalid, AXI_wvalid}, 2'b10);
    @(negedge AXI_CLK);
    chk("wr_c3_valids", {AXI_awvalid, AXI_wvalid}, 2'b10);
    @(negedge AXI_CLK);
    chk("wr_c4_bready", {AXI_bready, AXI_awvalid}, 2'b10);
    wait_done(0);
    chk("wr_latency", done_cyc[0] - acc_cyc[0], 5);
    chk("wr_rdata_kept", req0_rdata, 32'hDEAD_BEEF);
    aw_dly = 0;

    // Error read then error write on req1.
    s_rdata = 32'h1111_2222; s_rresp = 2'b10;
    issue(1, 0, 32'h20, 32'h0, 4'h0);
    wait_done(1);
    chk("err_rd_err", req1_err, 1);
    chk("err_rd_rdata", req1_rdata, 32'h1111_2222);
    s_rresp = 2'b00; s_bresp = 2'b11;
    issue(1, 1, 32'h24, 32'h5, 4'hF);
    wait_done(1);
    chk("err_wr_err", req1_err, 1);
    chk("err_wr_rdata_kept", req1_rdata, 32'h1111_2222);
    chk("err_other_rdata", req0_rdata, 32'hDEAD_BEEF);
    s_bresp = 2'b00;

    // Slow arready; req1 waits for req0 to finish.
    ar_dly = 20; s_rdata = 32'hCAFE_0001;
    fork
      begin
        int cnt;
        cnt = 0;
        issue(0, 0, 32'h40, 32'h0, 4'h0);
        for (int k = 0; k < 100; k++) begin
          @(negedge AXI_CLK);
          if (AXI_arvalid) cnt++;
          else break;
        end
        chk("slow_ar_cycles", cnt, 21);
        wait_done(0);
      end
      begin
        repeat (3) @(posedge AXI_CLK);
        issue(1, 0, 32'h44, 32'h0, 4'h0);
        wait_done(1);
      end
    join
    chk("slow_rd_latency", done_cyc[0] - acc_cyc[0], 23);
    chk("slow_req1_after_done", acc_cyc[1] - done_cyc[0], 1);
    ar_dly = 0;

    // Reset while waiting on rvalid.
    r_dly = 1000;
    issue(0, 0, 32'h80, 32'h0, 4'h0);
    @(negedge AXI_CLK);
    @(negedge AXI_CLK);
    chk("rst_mid_rready_before", AXI_rready, 1);
    #2 RESET = 1;
    #1;
    chk("rst_mid_rready", AXI_rready, 0);
    chk("rst_mid_valids", {AXI_arvalid, AXI_awvalid, AXI_wvalid, AXI_bready}, 0);
    chk("rst_mid_done", dut_done, 0);
    r_dly = 0;
    repeat (2) @(negedge AXI_CLK);
    RESET = 0;
    grant_log.delete();
    fork
      issue(0, 0, 32'h90, 32'h0, 4'h0);
      issue(1, 0, 32'h94, 32'h0, 4'h0);
    join
    wait_done(1);
    chk("post_rst_first", grant_log[0], 0);
    chk("post_rst_second", grant_log[1], 1);
    chk("post_rst_req1_rdata", req1_rdata, 32'hCAFE_0001);

    repeat (3) @(negedge AXI_CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
